// File: rtl/ahb_pkg.sv
// Shared encodings for the AHB-Lite to Wishbone bridge: AHB transfer types,
// transfer sizes, bridge FSM states and response codes.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WB,
        ST_RESP,
        ST_ERR1,
        ST_ERR2
    } bridge_state_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int unsigned WB_LANES = 4;

endpackage

// File: rtl/ahb_size_decode.sv
// Maps an AHB transfer size and the low address bits onto Wishbone byte
// strobes, and flags accesses the bridge must refuse.
module ahb_size_decode
    import ahb_pkg::*;
(
    input  logic [1:0]          addr_lo_i,
    input  logic [2:0]          hsize_i,
    output logic [WB_LANES-1:0] sel_o,
    output logic                misaligned_o
);

    // Sizes above a word are folded into misaligned_o: both are refused the same way.
    always_comb begin
        sel_o        = '0;
        misaligned_o = 1'b0;
        case (hsize_i)
            HSIZE_BYTE: begin
                sel_o = 4'b0001 << addr_lo_i;
            end
            HSIZE_HALF: begin
                sel_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misaligned_o = addr_lo_i[0];
            end
            HSIZE_WORD: begin
                sel_o        = '1;
                misaligned_o = |addr_lo_i;
            end
            default: begin
                misaligned_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ahb_wb_bridge.sv
// AHB-Lite subordinate to Wishbone-classic master: one AHB transfer becomes one
// WB cycle, single outstanding, with alignment checks and an ack timeout.
module ahb_wb_bridge
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_core,
    input  logic                    rst_core,
    input  logic [ADDR_WIDTH-1:0]   haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [2:0]              hburst,
    input  logic [3:0]              hprot,
    input  logic                    hmastlock,
    input  logic                    hready,
    input  logic [DATA_WIDTH-1:0]   hwdata,
    output logic                    hreadyout,
    output logic                    hresp,
    output logic [DATA_WIDTH-1:0]   hrdata,
    output logic                    wb_cyc,
    output logic                    wb_stb,
    output logic                    wb_we,
    output logic [DATA_WIDTH/8-1:0] wb_sel,
    output logic [ADDR_WIDTH-1:0]   wb_adr,
    output logic [DATA_WIDTH-1:0]   wb_dat_w,
    input  logic [DATA_WIDTH-1:0]   wb_dat_r,
    input  logic                    wb_ack
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    bridge_state_e               state_q, state_d;
    logic                        hreadyout_q, hreadyout_d;
    logic                        hresp_q, hresp_d;
    logic [DATA_WIDTH-1:0]       hrdata_q, hrdata_d;
    logic                        cyc_q, cyc_d;
    logic                        we_q, we_d;
    logic [DATA_WIDTH/8-1:0]     sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]       adr_q, adr_d;
    logic [DATA_WIDTH-1:0]       dat_w_q, dat_w_d;
    logic                        write_q, write_d;
    logic [CNT_W-1:0]            tcnt_q, tcnt_d;

    logic [WB_LANES-1:0]         dec_sel;
    logic                        dec_bad;
    logic                        accept;
    logic                        ack_seen;
    logic                        expired;
    logic                        unused_ahb;

    assign unused_ahb = ^{hburst, hprot, hmastlock};

    ahb_size_decode u_size_decode (
        .addr_lo_i    (haddr[1:0]),
        .hsize_i      (hsize),
        .sel_o        (dec_sel),
        .misaligned_o (dec_bad)
    );

    assign accept = hready
                  && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ)
                  && (state_q == ST_IDLE || state_q == ST_RESP || state_q == ST_ERR2);

    // An ack outside an open cycle (e.g. a late ack after timeout) is never honoured.
    assign ack_seen = wb_ack && cyc_q;
    assign expired  = (TIMEOUT_CYCLES != 0) && (tcnt_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        hrdata_d    = hrdata_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_w_d     = dat_w_q;
        write_d     = write_q;
        tcnt_d      = tcnt_q;

        case (state_q)
            ST_IDLE, ST_RESP, ST_ERR2: begin
                state_d     = ST_IDLE;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_OKAY;
                if (accept) begin
                    write_d = hwrite;
                    if (dec_bad) begin
                        state_d     = ST_ERR1;
                        hreadyout_d = 1'b0;
                        hresp_d     = HRESP_ERROR;
                    end else begin
                        adr_d       = {haddr[ADDR_WIDTH-1:2], 2'b00};
                        sel_d       = dec_sel;
                        hreadyout_d = 1'b0;
                        tcnt_d      = '0;
                        if (hwrite) begin
                            state_d = ST_WDATA;
                        end else begin
                            state_d = ST_WB;
                            cyc_d   = 1'b1;
                            we_d    = 1'b0;
                        end
                    end
                end
            end
            ST_WDATA: begin
                dat_w_d = hwdata;
                cyc_d   = 1'b1;
                we_d    = 1'b1;
                tcnt_d  = '0;
                state_d = ST_WB;
            end
            ST_WB: begin
                // Ack is tested first so a simultaneous ack and expiry completes OKAY.
                if (ack_seen) begin
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    state_d     = ST_RESP;
                    hreadyout_d = 1'b1;
                    hresp_d     = HRESP_OKAY;
                    if (!write_q) begin
                        hrdata_d = wb_dat_r;
                    end
                end else if (expired) begin
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    state_d     = ST_ERR1;
                    hreadyout_d = 1'b0;
                    hresp_d     = HRESP_ERROR;
                end else begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                end
            end
            ST_ERR1: begin
                state_d     = ST_ERR2;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_ERROR;
            end
            default: begin
                state_d     = ST_IDLE;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_OKAY;
                cyc_d       = 1'b0;
                we_d        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_w_q     <= '0;
            write_q     <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_w_q     <= dat_w_d;
            write_q     <= write_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;
    assign hrdata    = hrdata_q;
    assign wb_cyc    = cyc_q;
    assign wb_stb    = cyc_q;
    assign wb_we     = we_q;
    assign wb_sel    = sel_q;
    assign wb_adr    = adr_q;
    assign wb_dat_w  = dat_w_q;

endmodule
